enc_bind_sequencer: RTL and testbench
=====================================

Name: enc_bind_sequencer

Overview:
- Sequences the encoder's binder bank over a full feature vector, one chunk of FEATURES_PER_CC features per pass.
- Per chunk it:
  - requests level hypervectors from the level/item memory;
  - fires a one-cycle start_binding pulse to the binder pack;
  - waits out the binder latency;
  - hands the shifted chunk to the bundler over a valid/ready handshake.
- Sits between the encoder top-level control and the binder pack(s).

Parameters:
- NUM_FEATURES, 617, total features per sample.
- FEATURES_PER_CC, 3, features bound per chunk; equals the binder pack lane count.
- BIND_LAT, 1, cycles from start_binding to binder outputs stable; legal values >= 1.
- NUM_CHUNKS, ceil(NUM_FEATURES/FEATURES_PER_CC) (=206), derived; do not override.
- CW, $clog2(NUM_CHUNKS), derived chunk index width.
- FW, $clog2(NUM_FEATURES), derived feature address width.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- start, input, 1: begin encoding one sample; honoured only in IDLE.
- abort, input, 1: synchronous cancel of the current sample.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the last chunk is accepted.
- lvl_req, output, 1: level-HV fetch request for the current chunk.
- lvl_valid, input, 1: level HVs present at the binder inputs; handshake is lvl_req & lvl_valid.
- feat_addr, output, FW: first feature index of the current chunk, = chunk*FEATURES_PER_CC.
- chunk_idx, output, CW: current chunk number.
- lane_mask, output, FEATURES_PER_CC: valid lanes of the current chunk.
- start_binding, output, 1: one-cycle pulse to the binder pack.
- out_valid, output, 1: shifted chunk available to the bundler.
- out_ready, input, 1: bundler accepts; handshake is out_valid & out_ready.
- out_last, output, 1: qualifies out_valid on the final chunk.
- stall_cycles, output, 32: performance counter (see Optional Feature).

Behaviour:
- Reset: state=IDLE; chunk=0, latency counter=0; all outputs 0 except lane_mask, which resets to all-ones. All outputs are registered.
- IDLE → FETCH on start. chunk ← 0. start while busy is ignored.
- FETCH:
  - lvl_req=1, feat_addr/chunk_idx/lane_mask driven.
  - Hold until lvl_valid. On the handshake cycle t → BIND.
- BIND:
  - start_binding=1 in cycle t+1 only.
  - Remain in BIND for BIND_LAT cycles, then → EMIT.
  - out_valid rises exactly BIND_LAT cycles after the start_binding cycle.
  - lvl_req=0 throughout.
- EMIT:
  - out_valid=1 and out_last=(chunk==NUM_CHUNKS-1), both held stable until the handshake.
  - On handshake: if last → DONE; else chunk+1, → FETCH.
- DONE: done=1 for one cycle, busy=1 → IDLE.
- Throughput with lvl_valid=out_ready=1: 2+BIND_LAT cycles per chunk.
- lane_mask:
  - All-ones except the last chunk, where only bits [REM-1:0] are set.
  - REM = NUM_FEATURES-(NUM_CHUNKS-1)*FEATURES_PER_CC. With defaults, REM=2 → 3'b011.
  - If REM==FEATURES_PER_CC, the last chunk is all-ones.
- Simultaneous events:
  - abort has priority over every transition, including a handshake in the same cycle.
  - start with abort in IDLE: abort wins and the FSM stays in IDLE.
- abort in any non-IDLE state:
  - Next cycle IDLE; outputs as after reset; chunk=0.
  - No done pulse. A pending start_binding is not issued.
- Asynchronous rst mid-operation: immediate return to reset values. No output glitch is permitted after rst deasserts.
- Chunk counter never wraps. The NUM_CHUNKS-1 → DONE path is the only exit.

Optional Feature:
- Macro: ENC_SEQ_PERF_EN.
- Defined:
  - stall_cycles counts cycles with (out_valid & !out_ready) or (lvl_req & !lvl_valid).
  - 32-bit, saturates at 32'hFFFF_FFFF.
  - Cleared on an accepted start; holds its value after done.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised.

Test Plan:
1. Defaults, lvl_valid=out_ready=1, start at cycle 0:
   - FETCH at cycle 1; chunk k emits at cycle 3+3k.
   - out_last with chunk_idx=205, lane_mask=3'b011, feat_addr=615 at cycle 618.
   - done at cycle 619; exactly 206 start_binding pulses.
2. BIND_LAT=4:
   - start_binding at cycle t+1 and out_valid at t+5 after the lvl handshake at t.
   - 6 cycles per chunk.
3. Backpressure: out_ready=0 for 10 cycles on chunk 7:
   - out_valid, chunk_idx=7 and feat_addr=21 held stable.
   - No FETCH for chunk 8 until the handshake.
   - With ENC_SEQ_PERF_EN, stall_cycles=10.
4. lvl_valid held low 5 cycles on chunk 0:
   - lvl_req stays 1 and start_binding stays 0 throughout.
   - The pulse appears 1 cycle after lvl_valid rises.
5. abort in the same cycle as the out handshake on chunk 50:
   - IDLE next cycle, busy=0, no done.
   - A following start restarts at chunk_idx=0, feat_addr=0.
6. rst asserted mid-BIND:
   - All outputs 0 (lane_mask all-ones) asynchronously.
   - start while busy, after restart, has no effect on chunk_idx.

Source files
------------

// File: rtl/enc_bind_sequencer_if.sv
// Binder-bank sequencing bus: level-HV fetch and chunk hand-off to the bundler.
// Valid/ready: a transfer happens only in a cycle where both sides are high (lvl_req & lvl_valid, out_valid & out_ready); the initiator holds its request and payload stable until that cycle.
interface enc_bind_sequencer_if #(
  parameter int FW    = 10,
  parameter int CW    = 8,
  parameter int LANES = 3
);
  logic             lvl_req;
  logic             lvl_valid;
  logic [FW-1:0]    feat_addr;
  logic [CW-1:0]    chunk_idx;
  logic [LANES-1:0] lane_mask;
  logic             start_binding;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output lvl_req, feat_addr, chunk_idx, lane_mask, start_binding, out_valid, out_last,
    input  lvl_valid, out_ready
  );

  modport slave (
    input  lvl_req, feat_addr, chunk_idx, lane_mask, start_binding, out_valid, out_last,
    output lvl_valid, out_ready
  );
endinterface

// File: rtl/enc_bind_sequencer.sv
// Walks the feature vector chunk by chunk: fetch level HVs, pulse the binders, wait out their latency, hand the chunk to the bundler.
// Optional stall counter enabled by defining ENC_SEQ_PERF_EN.
module enc_bind_sequencer #(
  parameter int  NUM_FEATURES    = 617,
  parameter int  FEATURES_PER_CC = 3,
  parameter int  BIND_LAT        = 1,
  localparam int NUM_CHUNKS      = (NUM_FEATURES + FEATURES_PER_CC - 1) / FEATURES_PER_CC,
  localparam int CW              = $clog2(NUM_CHUNKS),
  localparam int FW              = $clog2(NUM_FEATURES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cycles,
  output logic [2:0]  dbg_state,
  enc_bind_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_BIND  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int LW  = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;
  localparam int REM = NUM_FEATURES - (NUM_CHUNKS - 1) * FEATURES_PER_CC;
  localparam logic [FEATURES_PER_CC-1:0] ALL_LANES  = '1;
  localparam logic [FEATURES_PER_CC-1:0] LAST_LANES = ALL_LANES >> (FEATURES_PER_CC - REM);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [LW-1:0] LAT_MAX    = LW'(BIND_LAT - 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              chunk_q, chunk_d;
  logic [LW-1:0]              lat_q, lat_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       lvl_req_q, lvl_req_d;
  logic                       start_binding_q, start_binding_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [FW-1:0]              feat_addr_q, feat_addr_d;
  logic [FEATURES_PER_CC-1:0] lane_mask_q, lane_mask_d;

  // abort overrides every transition, including a handshake in the same cycle
  always_comb begin
    state_d         = state_q;
    chunk_d         = chunk_q;
    lat_d           = lat_q;
    start_binding_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      chunk_d = '0;
      lat_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_FETCH;
          chunk_d = '0;
        end
        S_FETCH: if (bus.lvl_valid) begin
          state_d         = S_BIND;
          lat_d           = '0;
          start_binding_d = 1'b1;
        end
        S_BIND: begin
          if (lat_q == LAT_MAX) begin
            state_d = S_EMIT;
            lat_d   = '0;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        S_EMIT: if (bus.out_ready) begin
          if (chunk_q == LAST_CHUNK) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            chunk_d = chunk_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          chunk_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          chunk_d = '0;
          lat_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    lvl_req_d   = (state_d == S_FETCH);
    out_valid_d = (state_d == S_EMIT);
    out_last_d  = (state_d == S_EMIT) && (chunk_d == LAST_CHUNK);
    feat_addr_d = FW'(int'(chunk_d) * FEATURES_PER_CC);
    lane_mask_d = ALL_LANES;
    if ((state_d != S_IDLE) && (chunk_d == LAST_CHUNK)) lane_mask_d = LAST_LANES;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      chunk_q         <= '0;
      lat_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      lvl_req_q       <= 1'b0;
      start_binding_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      feat_addr_q     <= '0;
      lane_mask_q     <= '1;
    end else begin
      state_q         <= state_d;
      chunk_q         <= chunk_d;
      lat_q           <= lat_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      lvl_req_q       <= lvl_req_d;
      start_binding_q <= start_binding_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      feat_addr_q     <= feat_addr_d;
      lane_mask_q     <= lane_mask_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign dbg_state         = state_q;
  assign bus.lvl_req       = lvl_req_q;
  assign bus.start_binding = start_binding_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.feat_addr     = feat_addr_q;
  assign bus.chunk_idx     = chunk_q;
  assign bus.lane_mask     = lane_mask_q;

`ifdef ENC_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!abort && (state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (((out_valid_q && !bus.out_ready) || (lvl_req_q && !bus.lvl_valid))
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_enc_bind_sequencer.sv
// Randomized scoreboard bench for enc_bind_sequencer: expected chunks are queued at start, a negedge monitor checks order, timing and handshake rules.
module tb_enc_bind_sequencer;
  localparam int NF  = 617;
  localparam int FPC = 3;
  localparam int BL  = 1;
  localparam int NC  = (NF + FPC - 1) / FPC;
  localparam int CW  = $clog2(NC);
  localparam int FW  = $clog2(NF);
  localparam int W   = 1 + FPC + FW + CW;
  localparam int REM = NF - (NC - 1) * FPC;
  localparam logic [FPC-1:0] ALL1 = '1;
`ifdef ENC_SEQ_PERF_EN
  localparam logic [31:0] EXP_DIR_STALL = 32'd15;
`else
  localparam logic [31:0] EXP_DIR_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] stall_cycles;
  logic [2:0]  dbg_state;

  enc_bind_sequencer_if #(.FW(FW), .CW(CW), .LANES(FPC)) bus ();

  enc_bind_sequencer #(
    .NUM_FEATURES(NF), .FEATURES_PER_CC(FPC), .BIND_LAT(BL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .stall_cycles(stall_cycles), .dbg_state(dbg_state),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_c = 0;
  int mode   = 3;
  bit full_tp = 1'b0;
  int lhold = 0;
  int ohold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: chunk k covers features [k*FPC, k*FPC+FPC) clipped to NF
  function automatic logic [W-1:0] exp_chunk(input int k);
    logic           last;
    logic [FPC-1:0] m;
    last = (k == NC - 1);
    for (int i = 0; i < FPC; i++) m[i] = (k * FPC + i < NF);
    return {last, m, FW'(k * FPC), CW'(k)};
  endfunction

  // ---------------- background input driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: begin
          bus.lvl_valid = 1'b1;
          bus.out_ready = 1'b1;
        end
        1: begin
          bus.lvl_valid = ($urandom_range(0, 3) != 0);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        2: begin
          bus.lvl_valid = !(bus.lvl_req && bus.chunk_idx == 0 && lhold < 5);
          if (!bus.lvl_valid) lhold++;
          bus.out_ready = !(bus.out_valid && bus.chunk_idx == 7 && ohold < 10);
          if (!bus.out_ready) ohold++;
        end
        default: ;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic         p_ov, p_or, p_lr, p_lv, p_abort, p_busy, p_start, p_last_hs;
  logic [W-1:0] p_rec;
  logic [31:0]  st_m;
  int           last_sb;
  int           sb_cnt;

  initial begin
    logic [W-1:0] rec;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        {p_ov, p_or, p_lr, p_lv, p_abort, p_busy, p_start, p_last_hs} = '0;
        p_rec = '0; st_m = '0; last_sb = -1000; sb_cnt = 0;
      end else begin
        rec = {bus.out_last, bus.lane_mask, bus.feat_addr, bus.chunk_idx};
        check("start_binding", 64'(bus.start_binding), 64'(p_lr && p_lv && !p_abort));
        if (bus.start_binding) begin
          last_sb = cyc;
          sb_cnt++;
        end
        check("done_pulse", 64'(done), 64'(p_last_hs));
        if (p_abort)
          check("abort_state",
                64'({busy, done, bus.lvl_req, bus.start_binding, bus.out_valid, bus.out_last,
                     bus.chunk_idx, bus.feat_addr, bus.lane_mask}),
                64'({6'b0, CW'(0), FW'(0), ALL1}));
        if (p_start && !p_busy && !p_abort)
          check("fetch_after_start", 64'({busy, bus.lvl_req, bus.chunk_idx, bus.feat_addr}),
                64'({2'b11, CW'(0), FW'(0)}));
        if (p_ov && !p_or && !p_abort)
          check("out_hold", 64'({bus.out_valid, rec}), 64'({1'b1, p_rec}));
        if (p_lr && !p_lv && !p_abort)
          check("lvl_hold", 64'({bus.lvl_req, bus.start_binding, bus.chunk_idx}),
                64'({2'b10, p_rec[CW-1:0]}));
        if (bus.out_valid && !p_ov)
          check("bind_latency", 64'(cyc - last_sb), 64'(BL));
        check("lvl_req_exclusive", 64'(bus.lvl_req && (bus.out_valid || bus.start_binding)), 64'(0));
`ifdef ENC_SEQ_PERF_EN
        check("stall_cycles", 64'(stall_cycles), 64'(st_m));
`else
        check("stall_cycles", 64'(stall_cycles), 64'(0));
`endif
        if (bus.out_valid && bus.out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL chunk_order: got unexpected chunk %0h expected none (cycle %0d)", rec, cyc);
          end else begin
            e = exp_q.pop_front();
            check("chunk_fields", 64'(rec), 64'(e));
            if (full_tp)
              check("emit_cycle", 64'(cyc - start_c), 64'((2 + BL) * (int'(e[CW-1:0]) + 1)));
          end
        end
        if (done) begin
          check("bind_pulse_count", 64'(sb_cnt), 64'(NC));
          if (full_tp) check("done_cycle", 64'(cyc - start_c), 64'((2 + BL) * NC + 1));
        end
        if (abort) exp_q.delete();
        // behavioural stall counter: clear on accepted start, count waiting cycles, saturate
        if (start && !busy && !abort) begin
          st_m    = '0;
          sb_cnt  = 0;
          start_c = cyc;
        end else if (((bus.out_valid && !bus.out_ready) || (bus.lvl_req && !bus.lvl_valid))
                     && st_m != 32'hFFFF_FFFF) begin
          st_m = st_m + 32'd1;
        end
        p_ov = bus.out_valid; p_or = bus.out_ready; p_lr = bus.lvl_req; p_lv = bus.lvl_valid;
        p_abort = abort; p_busy = busy; p_start = start; p_rec = rec;
        p_last_hs = bus.out_valid && bus.out_ready && bus.out_last && !abort;
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sample(input int m, input bit ftp);
    @(posedge clk);
    #2;
    mode = m; full_tp = ftp; lhold = 0; ohold = 0;
    start = 1'b1;
    for (int k = 0; k < NC; k++) exp_q.push_back(exp_chunk(k));
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cyc);
    check("done_reached", 64'(done), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, bus.lvl_req, bus.start_binding, bus.out_valid, bus.out_last}), 64'(0));
    check({tag, "_chunk"}, 64'(bus.chunk_idx), 64'(0));
    check({tag, "_addr"}, 64'(bus.feat_addr), 64'(0));
    check({tag, "_mask"}, 64'(bus.lane_mask), 64'(ALL1));
    check({tag, "_stall"}, 64'(stall_cycles), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    bus.lvl_valid = 1'b0; bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // full throughput, cycle-exact timing
    start_sample(0, 1'b1);
    wait_done(2000);
    idle(3);

    // lvl stall on chunk 0, out backpressure on chunk 7
    start_sample(2, 1'b0);
    wait_done(3000);
    check("stall_directed", 64'(stall_cycles), 64'(EXP_DIR_STALL));
    idle(3);

    // random handshakes
    start_sample(1, 1'b0);
    wait_done(6000);
    idle(3);

    // abort coinciding with the out handshake of chunk 50
    start_sample(1, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(bus.out_valid && bus.chunk_idx == CW'(50)) && n < 5000);
    check("reach_chunk50", 64'(bus.chunk_idx), 64'(50));
    mode = 3;
    bus.out_ready = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    idle(3);
    check("idle_after_abort", 64'({busy, done}), 64'(0));

    // start and abort together in IDLE: stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0; abort = 1'b0;
    idle(2);

    // restart after abort begins at chunk 0
    start_sample(0, 1'b1);
    wait_done(2000);
    idle(3);

    // asynchronous reset mid-BIND
    start_sample(1, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(bus.start_binding && bus.chunk_idx >= CW'(3)) && n < 5000);
    check("reach_bind", 64'(bus.start_binding), 64'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    idle(2);

    // start pulses while busy must not disturb the sequence
    start_sample(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(5, 40));
      if (busy) begin
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    end
    wait_done(6000);
    idle(5);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
